sdram_arbit: RTL and testbench
==============================

# sdram_arbit

Command-bus arbiter for the SDRAM controller. It owns the single SDRAM command/address/data pins and shares them between the init, auto-refresh, write and read sub-modules. It holds the bus for the init sequence until `init_end`, then grants one requester at a time:

- refresh has strict priority;
- write and read alternate round-robin when both are pending.

While a requester is granted, its `{cmd, ba, addr}` and write data are multiplexed onto the pins.

## Interface
Parameters:
- `NOP_CMD`, 4'b0111: idle command `{cs_n,ras_n,cas_n,we_n}` driven when nobody is granted.
- `IDLE_BA`, 2'b11: idle bank value.
- `IDLE_ADDR`, 13'h1fff: idle address value.

Ports:
- `sys_clk`  in  1  system clock, 100 MHz.
- `sys_rst_n`  in  1  reset; one clock, reset asynchronous and active-low.
- `init_end`  in  1  init sequence finished (sticky high from the init module).
- `init_cmd` / `init_ba` / `init_addr`  in  4/2/13  init module command bus.
- `aref_req`  in  1  refresh request (level).
- `aref_cmd` / `aref_ba` / `aref_addr`  in  4/2/13  refresh command bus.
- `aref_end`  in  1  refresh done pulse.
- `wr_req`  in  1  write request (level, from write-FIFO level logic).
- `wr_cmd` / `wr_ba` / `wr_addr`  in  4/2/13  write command bus.
- `wr_end`  in  1  write burst done pulse.
- `wr_sdram_en`  in  1  write data output enable.
- `wr_sdram_data`  in  16  write data.
- `rd_req`  in  1  read request (level).
- `rd_cmd` / `rd_ba` / `rd_addr`  in  4/2/13  read command bus.
- `rd_end`  in  1  read burst done pulse.
- `aref_en`  out  1  refresh grant; connects to the refresh module enable.
- `wr_en`  out  1  write grant; connects to `sdram_write.wr_en`.
- `rd_en`  out  1  read grant.
- `sdram_cke`  out  1  clock enable, constant 1 after reset.
- `sdram_cs_n`, `sdram_ras_n`, `sdram_cas_n`, `sdram_we_n`  out  1 each  command pins.
- `sdram_ba`  out  2  bank address.
- `sdram_addr`  out  13  row/column address.
- `sdram_dq_out`  out  16  DQ output value.
- `sdram_dq_oe`  out  1  DQ tristate enable.

## Operation
States: `INIT`, `ARBIT`, `AREF`, `WRITE`, `READ`. State is a registered FSM.

Transitions:
- **INIT**: the pin bus follows the `init_*` inputs. Go to `ARBIT` when `init_end`=1. `init_end` is sampled only in `INIT`.
- **ARBIT**: the pin bus shows NOP/`IDLE_BA`/`IDLE_ADDR`. Decision order:
  - `aref_req` → `AREF`;
  - else only `wr_req` → `WRITE`;
  - else only `rd_req` → `READ`;
  - both `wr_req` and `rd_req` → the one not granted last (`last_wr` flag; reset value 0, so write wins first);
  - no request → stay in `ARBIT`.
- **AREF / WRITE / READ**: the pin bus follows the granted module's inputs. Leave to `ARBIT` on the cycle after the matching `*_end` is sampled high. `last_wr` updates when leaving `WRITE` (set) or `READ` (clear).

Grant and data rules:
- `aref_en` / `wr_en` / `rd_en` are registered: high exactly while the FSM is in the matching state. At most one is high at a time (one-hot).
- A request dropping while granted does not revoke the grant. Only `*_end` releases it.
- `*_end` pulses from a non-granted module are ignored.
- `sdram_dq_oe` = `wr_sdram_en` only in `WRITE`, else 0.
- `sdram_dq_out` = `wr_sdram_data` in `WRITE`, else 16'h0.

Reset mid-operation: all state returns to `INIT` asynchronously and all grants drop immediately. Sub-modules are on the same reset.

## Timing
- Reset values:
  - state = `INIT`, `last_wr` = 0;
  - all grants 0, `sdram_cke` = 0;
  - `sdram_dq_oe` = 0, `sdram_dq_out` = 0;
  - command pins = `init_cmd` passthrough (init drives NOP in reset).
- The pin mux is combinational from the registered state. Sub-module commands reach the pins with zero added latency.
- Grant latency: a request seen high at edge N in `ARBIT` → state and grant change at edge N, visible in cycle N+1.
- Release: `*_end` high in cycle M → grant low and state `ARBIT` from edge M+1.
- Bus turnaround: minimum 1 `ARBIT` cycle (NOP) between consecutive grants.
- Refresh latency is bounded by one in-flight burst plus 1 cycle. `aref_req` must stay high until `aref_en`.

## Structure
- Shared package `sdram_pkg`: SDRAM command encodings (`NOP`, `ACTIVE`, `READ`, `WRITE`, `B_TERM`, `PRECHARGE`, `AREF`, `LMR`), idle `ba`/`addr` constants, and arbiter state encodings. The command encodings are shared with the write, read and refresh modules.
- Single module, no sub-modules. The pin mux is one case on state.

## Test plan
1. Reset, then `init_end` high at cycle 10 → pins follow `init_*` until the edge after cycle 10, then NOP/2'b11/13'h1fff. All grants remain 0.
2. `wr_req`=1 alone → `wr_en` high from the next cycle; `wr_cmd`=4'b0011 appears on the pins the same cycle. `wr_end` pulse → `wr_en` low one cycle later; NOP on the pins.
3. `wr_req` and `rd_req` held high continuously → grants alternate W, R, W, R, each separated by exactly 1 NOP cycle.
4. `aref_req` rises during a write burst → no preemption. After `wr_end`, `aref_en` is granted before the pending `rd_req`.
5. During `WRITE` with `wr_sdram_en`=1 and data 16'hA5A5 → `sdram_dq_oe`=1 and `sdram_dq_out`=16'hA5A5. In `READ`, `sdram_dq_oe`=0 regardless of `wr_sdram_en`.
6. Assert `sys_rst_n`=0 mid-read → `rd_en` drops and state returns to `INIT` without a clock edge. A stray `rd_end` in `ARBIT` is ignored.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings {cs_n,ras_n,cas_n,we_n},
// idle bus values and the command-bus arbiter state encodings.
package sdram_pkg;

  typedef logic [3:0] sdram_cmd_t;

  localparam sdram_cmd_t CMD_NOP       = 4'b0111;
  localparam sdram_cmd_t CMD_ACTIVE    = 4'b0011;
  localparam sdram_cmd_t CMD_READ      = 4'b0101;
  localparam sdram_cmd_t CMD_WRITE     = 4'b0100;
  localparam sdram_cmd_t CMD_B_TERM    = 4'b0110;
  localparam sdram_cmd_t CMD_PRECHARGE = 4'b0010;
  localparam sdram_cmd_t CMD_AREF      = 4'b0001;
  localparam sdram_cmd_t CMD_LMR       = 4'b0000;

  localparam logic [1:0]  IDLE_BA_DEF   = 2'b11;
  localparam logic [12:0] IDLE_ADDR_DEF = 13'h1fff;

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_ARBIT = 3'd1;
  localparam logic [2:0] ST_AREF  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_READ  = 3'd4;

endpackage

// File: rtl/sdram_arbit.sv
// SDRAM command-bus arbiter: owns the pins during init, then grants refresh
// (strict priority) or write/read (round-robin) one at a time.
//
// state | meaning
// INIT  | init sequence owns the pins until init_end
// ARBIT | bus idle (NOP), choosing the next requester
// AREF  | auto-refresh owns the pins until aref_end
// WRITE | write burst owns pins and DQ until wr_end
// READ  | read burst owns the pins until rd_end
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter logic [3:0]  NOP_CMD   = CMD_NOP,
  parameter logic [1:0]  IDLE_BA   = IDLE_BA_DEF,
  parameter logic [12:0] IDLE_ADDR = IDLE_ADDR_DEF
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        init_end,
  input  logic [3:0]  init_cmd,
  input  logic [1:0]  init_ba,
  input  logic [12:0] init_addr,
  input  logic        aref_req,
  input  logic [3:0]  aref_cmd,
  input  logic [1:0]  aref_ba,
  input  logic [12:0] aref_addr,
  input  logic        aref_end,
  input  logic        wr_req,
  input  logic [3:0]  wr_cmd,
  input  logic [1:0]  wr_ba,
  input  logic [12:0] wr_addr,
  input  logic        wr_end,
  input  logic        wr_sdram_en,
  input  logic [15:0] wr_sdram_data,
  input  logic        rd_req,
  input  logic [3:0]  rd_cmd,
  input  logic [1:0]  rd_ba,
  input  logic [12:0] rd_addr,
  input  logic        rd_end,
  output logic        aref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_ba,
  output logic [12:0] sdram_addr,
  output logic [15:0] sdram_dq_out,
  output logic        sdram_dq_oe
);

  logic [2:0] state_q, state_d;
  logic       last_wr_q, last_wr_d;
  logic       aref_en_q, wr_en_q, rd_en_q, cke_q;
  logic [3:0] cmd_mux;

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    case (state_q)
      ST_INIT:  if (init_end) state_d = ST_ARBIT;
      ST_ARBIT: begin
        if (aref_req)              state_d = ST_AREF;
        else if (wr_req && rd_req) state_d = last_wr_q ? ST_READ : ST_WRITE;
        else if (wr_req)           state_d = ST_WRITE;
        else if (rd_req)           state_d = ST_READ;
      end
      ST_AREF:  if (aref_end) state_d = ST_ARBIT;
      ST_WRITE: if (wr_end) begin
        state_d   = ST_ARBIT;
        last_wr_d = 1'b1;
      end
      ST_READ:  if (rd_end) begin
        state_d   = ST_ARBIT;
        last_wr_d = 1'b0;
      end
      default:  state_d = ST_INIT;
    endcase
  end

  // Grants are registered from the next state so they track state exactly.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_INIT;
      last_wr_q <= 1'b0;
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      cke_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      aref_en_q <= (state_d == ST_AREF);
      wr_en_q   <= (state_d == ST_WRITE);
      rd_en_q   <= (state_d == ST_READ);
      cke_q     <= 1'b1;
    end
  end

  always_comb begin
    cmd_mux      = NOP_CMD;
    sdram_ba     = IDLE_BA;
    sdram_addr   = IDLE_ADDR;
    sdram_dq_out = 16'h0;
    sdram_dq_oe  = 1'b0;
    case (state_q)
      ST_INIT: begin
        cmd_mux    = init_cmd;
        sdram_ba   = init_ba;
        sdram_addr = init_addr;
      end
      ST_AREF: begin
        cmd_mux    = aref_cmd;
        sdram_ba   = aref_ba;
        sdram_addr = aref_addr;
      end
      ST_WRITE: begin
        cmd_mux      = wr_cmd;
        sdram_ba     = wr_ba;
        sdram_addr   = wr_addr;
        sdram_dq_out = wr_sdram_data;
        sdram_dq_oe  = wr_sdram_en;
      end
      ST_READ: begin
        cmd_mux    = rd_cmd;
        sdram_ba   = rd_ba;
        sdram_addr = rd_addr;
      end
      default: ;
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_mux;
  assign aref_en   = aref_en_q;
  assign wr_en     = wr_en_q;
  assign rd_en     = rd_en_q;
  assign sdram_cke = cke_q;

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: directed vector table, reset/stray-end sequences,
// then random traffic against a bus-ownership reference model.
module tb_sdram_arbit;

  logic        sys_clk, sys_rst_n;
  logic        init_end;
  logic [3:0]  init_cmd, aref_cmd, wr_cmd, rd_cmd;
  logic [1:0]  init_ba, aref_ba, wr_ba, rd_ba;
  logic [12:0] init_addr, aref_addr, wr_addr, rd_addr;
  logic        aref_req, aref_end, wr_req, wr_end, rd_req, rd_end;
  logic        wr_sdram_en;
  logic [15:0] wr_sdram_data;
  logic        aref_en, wr_en, rd_en, sdram_cke;
  logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;
  logic [15:0] sdram_dq_out;
  logic        sdram_dq_oe;

  sdram_arbit dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_end(init_end),
    .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
    .aref_req(aref_req), .aref_cmd(aref_cmd), .aref_ba(aref_ba),
    .aref_addr(aref_addr), .aref_end(aref_end),
    .wr_req(wr_req), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
    .wr_end(wr_end), .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
    .rd_req(rd_req), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
    .rd_end(rd_end), .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
    .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba),
    .sdram_addr(sdram_addr), .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the bus, and whether write was served last.
  localparam int OWN_INIT = 0, OWN_IDLE = 1, OWN_AREF = 2, OWN_WR = 3, OWN_RD = 4;
  int m_owner;
  bit m_last_wr;
  bit m_cke;

  typedef struct {
    logic       init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end, wsen;
    logic [2:0] grant;   // {aref_en, wr_en, rd_en}
    logic [3:0] cmd;
    logic       oe;
    logic [15:0] dq;
  } vec_t;
  vec_t tv[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner   = OWN_INIT;
    m_last_wr = 1'b0;
    m_cke     = 1'b0;
  endtask

  task automatic model_edge();
    m_cke = 1'b1;
    case (m_owner)
      OWN_INIT: if (init_end) m_owner = OWN_IDLE;
      OWN_IDLE: begin
        if (aref_req) m_owner = OWN_AREF;
        else if (wr_req && rd_req) m_owner = m_last_wr ? OWN_RD : OWN_WR;
        else if (wr_req) m_owner = OWN_WR;
        else if (rd_req) m_owner = OWN_RD;
      end
      OWN_AREF: if (aref_end) m_owner = OWN_IDLE;
      OWN_WR:   if (wr_end) begin m_owner = OWN_IDLE; m_last_wr = 1'b1; end
      OWN_RD:   if (rd_end) begin m_owner = OWN_IDLE; m_last_wr = 1'b0; end
      default:  m_owner = OWN_INIT;
    endcase
  endtask

  task automatic check_all();
    logic [3:0]  e_cmd;
    logic [1:0]  e_ba;
    logic [12:0] e_addr;
    e_cmd = 4'b0111; e_ba = 2'b11; e_addr = 13'h1fff;
    case (m_owner)
      OWN_INIT: begin e_cmd = init_cmd; e_ba = init_ba; e_addr = init_addr; end
      OWN_AREF: begin e_cmd = aref_cmd; e_ba = aref_ba; e_addr = aref_addr; end
      OWN_WR:   begin e_cmd = wr_cmd;   e_ba = wr_ba;   e_addr = wr_addr;   end
      OWN_RD:   begin e_cmd = rd_cmd;   e_ba = rd_ba;   e_addr = rd_addr;   end
      default: ;
    endcase
    chk("grants", 32'({aref_en, wr_en, rd_en}),
        32'({m_owner == OWN_AREF, m_owner == OWN_WR, m_owner == OWN_RD}));
    chk("cke", 32'(sdram_cke), 32'(m_cke));
    chk("cmd", 32'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}), 32'(e_cmd));
    chk("ba", 32'(sdram_ba), 32'(e_ba));
    chk("addr", 32'(sdram_addr), 32'(e_addr));
    chk("dq_oe", 32'(sdram_dq_oe), 32'((m_owner == OWN_WR) && wr_sdram_en));
    chk("dq_out", 32'(sdram_dq_out), (m_owner == OWN_WR) ? 32'(wr_sdram_data) : 32'h0);
  endtask

  task automatic cycle();
    @(posedge sys_clk);
    if (sys_rst_n) model_edge();
    #1;
    check_all();
  endtask

  task automatic async_reset_check();
    #2;
    sys_rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("rst_grants", 32'({aref_en, wr_en, rd_en}), 32'h0);
    #2;
    sys_rst_n = 1'b1;
  endtask

  task automatic apply_vec(input vec_t v);
    init_end = v.init_end; aref_req = v.aref_req; aref_end = v.aref_end;
    wr_req = v.wr_req; wr_end = v.wr_end; rd_req = v.rd_req; rd_end = v.rd_end;
    wr_sdram_en = v.wsen;
  endtask

  initial begin
    // init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end, wsen, grant, cmd, oe, dq
    tv[0]  = '{0,0,0,0,0,0,0,0, 3'b000, 4'b0010, 0, 16'h0};     // still INIT
    tv[1]  = '{1,0,0,0,0,0,0,0, 3'b000, 4'b0111, 0, 16'h0};     // init done
    tv[2]  = '{1,0,0,1,0,0,0,0, 3'b010, 4'b0011, 0, 16'hA5A5};  // write granted
    tv[3]  = '{1,0,0,0,0,0,0,1, 3'b010, 4'b0011, 1, 16'hA5A5};  // req drop keeps grant
    tv[4]  = '{1,0,0,0,1,0,0,1, 3'b000, 4'b0111, 0, 16'h0};     // wr_end releases
    tv[5]  = '{1,0,0,0,0,0,1,0, 3'b000, 4'b0111, 0, 16'h0};     // stray rd_end
    tv[6]  = '{1,0,0,1,0,1,0,0, 3'b001, 4'b0101, 0, 16'h0};     // read wins (write last)
    tv[7]  = '{1,0,0,1,0,1,1,0, 3'b000, 4'b0111, 0, 16'h0};
    tv[8]  = '{1,0,0,1,0,1,0,0, 3'b010, 4'b0011, 0, 16'hA5A5};  // write wins
    tv[9]  = '{1,1,0,1,0,1,0,0, 3'b010, 4'b0011, 0, 16'hA5A5};  // no preemption
    tv[10] = '{1,1,0,1,1,1,0,0, 3'b000, 4'b0111, 0, 16'h0};
    tv[11] = '{1,1,0,1,0,1,0,0, 3'b100, 4'b0001, 0, 16'h0};     // refresh before read
    tv[12] = '{1,0,0,1,1,1,0,0, 3'b100, 4'b0001, 0, 16'h0};     // foreign wr_end ignored
    tv[13] = '{1,0,1,1,0,1,0,0, 3'b000, 4'b0111, 0, 16'h0};
    tv[14] = '{1,0,0,1,0,1,0,1, 3'b001, 4'b0101, 0, 16'h0};     // read, oe stays 0

    sys_rst_n = 1'b0;
    init_end = 0; aref_req = 0; aref_end = 0; wr_req = 0; wr_end = 0;
    rd_req = 0; rd_end = 0; wr_sdram_en = 0; wr_sdram_data = 16'hA5A5;
    init_cmd = 4'b0010; aref_cmd = 4'b0001; wr_cmd = 4'b0011; rd_cmd = 4'b0101;
    init_ba = 2'b01; aref_ba = 2'b10; wr_ba = 2'b00; rd_ba = 2'b01;
    init_addr = 13'h0400; aref_addr = 13'h0123; wr_addr = 13'h0a55; rd_addr = 13'h1234;
    model_reset();
    #12;
    check_all();
    sys_rst_n = 1'b1;

    for (int i = 0; i < 9; i++) cycle();

    for (int i = 0; i < 15; i++) begin
      apply_vec(tv[i]);
      cycle();
      chk($sformatf("tv%0d_grant", i), 32'({aref_en, wr_en, rd_en}), 32'(tv[i].grant));
      chk($sformatf("tv%0d_cmd", i),
          32'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}), 32'(tv[i].cmd));
      chk($sformatf("tv%0d_oe", i), 32'(sdram_dq_oe), 32'(tv[i].oe));
      chk($sformatf("tv%0d_dq", i), 32'(sdram_dq_out), 32'(tv[i].dq));
    end

    // Reset in the middle of the read grant, no clock edge needed.
    async_reset_check();
    chk("rst_rd_en", 32'(rd_en), 32'h0);
    chk("rst_cmd_init", 32'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}), 32'(init_cmd));
    apply_vec('{1,0,0,0,0,0,0,0, 3'b000, 4'b0, 0, 16'h0});
    cycle();
    rd_end = 1'b1;
    cycle();
    chk("stray_rd_end_grant", 32'({aref_en, wr_en, rd_en}), 32'h0);
    chk("stray_rd_end_nop", 32'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}), 32'h7);
    rd_end = 1'b0;

    // Random traffic; aref_req is held until granted, as the refresh module does.
    async_reset_check();
    init_end = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      init_cmd = 4'($urandom); aref_cmd = 4'($urandom);
      wr_cmd = 4'($urandom); rd_cmd = 4'($urandom);
      init_ba = 2'($urandom); aref_ba = 2'($urandom);
      wr_ba = 2'($urandom); rd_ba = 2'($urandom);
      init_addr = 13'($urandom); aref_addr = 13'($urandom);
      wr_addr = 13'($urandom); rd_addr = 13'($urandom);
      wr_sdram_data = 16'($urandom); wr_sdram_en = 1'($urandom);
      if (!init_end) init_end = ($urandom_range(0, 7) == 0);
      if (aref_en || !aref_req) aref_req = ($urandom_range(0, 29) == 0);
      wr_req   = ($urandom_range(0, 2) != 0);
      rd_req   = ($urandom_range(0, 2) != 0);
      aref_end = ($urandom_range(0, 5) == 0);
      wr_end   = ($urandom_range(0, 5) == 0);
      rd_end   = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 499) == 0) begin
        async_reset_check();
        init_end = 1'b0;
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
